// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter: FSM state type, frame length and
// a width helper for the saturating counters.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_GAP   = 3'd4
   } arb_state_t;

   localparam int unsigned UART_FRAME_BITS = 10;

   // Bits needed to hold the values 0..n-1, never less than one.
   function automatic int unsigned width_of(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester above 'last', wrapping mod N.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 any
);

   logic [$clog2(N)-1:0] idx;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      idx    = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = ($clog2(N))'((32'(last) + k) % N);
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx serialiser among N byte requesters; one
// byte per grant, held on tx_data until the serialiser reports end of frame.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N           = 4,
   parameter int unsigned GAP_CYC     = 0,
   parameter int unsigned TIMEOUT_CYC = 20000
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   input  logic                 ctrl_en,
   input  logic [N-1:0]         req_valid,
   input  logic [8*N-1:0]       req_data,
   output logic [N-1:0]         req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_data_en,
   input  logic                 tx_finish,
   output logic [$clog2(N)-1:0] grant_id,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned TW = width_of(TIMEOUT_CYC);
   localparam int unsigned GW = width_of(GAP_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

   arb_state_t     state, state_nxt;
   logic [IW-1:0]  last;
   logic [N-1:0]   gnt;
   logic [IW-1:0]  gnt_id;
   logic           any;
   logic           accept;
   logic           tmo_hit;
   logic           gap_done;
   logic [TW-1:0]  tmo_cnt;
   logic [GW-1:0]  gap_cnt;

   rr_arbiter #(.N(N)) u_rr (
      .req    (req_valid),
      .last   (last),
      .gnt    (gnt),
      .gnt_id (gnt_id),
      .any    (any)
   );

   assign tmo_hit  = (tmo_cnt == TMO_LAST);
   assign gap_done = (gap_cnt == GAP_LAST);

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      tx_data_en  = 1'b0;
      timeout_err = 1'b0;
      busy        = 1'b0;
      case (state)
         ST_INIT: begin
            if (tx_finish || tmo_hit) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (ctrl_en && any) begin
               accept    = 1'b1;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            tx_data_en = 1'b1;
            busy       = 1'b1;
            state_nxt  = ST_WAIT;
         end
         ST_WAIT: begin
            busy = 1'b1;
            // end of frame beats a timeout landing in the same cycle
            if (tx_finish) begin
               state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            end else if (tmo_hit) begin
               timeout_err = 1'b1;
               state_nxt   = ST_IDLE;
            end
         end
         ST_GAP: begin
            busy = 1'b1;
            if (gap_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      req_ready = accept ? gnt : '0;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state <= ST_INIT;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         last     <= IW'(N - 1);
         tx_data  <= '0;
         grant_id <= '0;
      end else if (accept) begin
         last     <= gnt_id;
         tx_data  <= req_data[8*gnt_id +: 8];
         grant_id <= gnt_id;
      end
   end

   // Timeout counter runs in INIT and WAIT only and stops at its limit.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
         gap_cnt <= '0;
      end else begin
         if (state == ST_INIT || state == ST_WAIT) begin
            if (!tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end
         if (state == ST_GAP) begin
            if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end
      end
   end

endmodule
